cory_scale_ctrl: RTL and testbench

//  Frame-level sequencer for a 2-D scaler built around the horizontal sampler (cory_sample).
//  - Accepts one frame command and emits one horizontal line command per output line (in_cnt/out_cnt/ratio).
//  - Emits a matching vertical descriptor per output line: integer source line, 8-bit phase, and input-line advance.
//  - Downstream line-buffer/vertical-filter logic uses the descriptor to sequence source lines.

---
 rtl/cory_scale_ctrl_if.sv | 61 ++++++
 rtl/cory_scale_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cory_scale_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cory_scale_ctrl_if.sv
// ---------------------------------------------------------------------------
// cory_scale_ctrl_if
//   Bundles the three handshake channels of the scaler frame sequencer:
//     frame command   : frm_v/frm_r + frame geometry and 8.8 ratios
//     horizontal cmd  : h_v/h_r + in_cnt/out_cnt/ratio for the sampler
//     vertical desc   : v_v/v_r + line/pos/phase/adv for the line buffer
//   plus the busy/done status.
//   slave  : the sequencer side (cory_scale_ctrl).
//   master : the environment side (frame source and line consumers).
// Parameter
//   R : resolution bits for width/height/position fields.
// ---------------------------------------------------------------------------
interface cory_scale_ctrl_if #(
  parameter int R = 11
);
  // Frame command
  logic          frm_v;
  logic [R-1:0]  frm_in_w;
  logic [R-1:0]  frm_in_h;
  logic [R-1:0]  frm_out_w;
  logic [R-1:0]  frm_out_h;
  logic [15:0]   frm_hratio;
  logic [15:0]   frm_vratio;
  logic          frm_r;
  // Horizontal line command
  logic          h_v;
  logic [R-1:0]  h_in_cnt;
  logic [R-1:0]  h_out_cnt;
  logic [15:0]   h_ratio;
  logic          h_r;
  // Vertical line descriptor
  logic          v_v;
  logic [R-1:0]  v_line;
  logic [R-1:0]  v_pos;
  logic [7:0]    v_phase;
  logic [R-1:0]  v_adv;
  logic          v_r;
  // Status
  logic          busy;
  logic          done;

  modport slave (
    input  frm_v, frm_in_w, frm_in_h, frm_out_w, frm_out_h, frm_hratio, frm_vratio,
    output frm_r,
    output h_v, h_in_cnt, h_out_cnt, h_ratio,
    input  h_r,
    output v_v, v_line, v_pos, v_phase, v_adv,
    input  v_r,
    output busy, done
  );

  modport master (
    output frm_v, frm_in_w, frm_in_h, frm_out_w, frm_out_h, frm_hratio, frm_vratio,
    input  frm_r,
    input  h_v, h_in_cnt, h_out_cnt, h_ratio,
    output h_r,
    input  v_v, v_line, v_pos, v_phase, v_adv,
    output v_r,
    input  busy, done
  );
endinterface

// File: rtl/cory_scale_ctrl.sv
// ---------------------------------------------------------------------------
// cory_scale_ctrl
//   Frame-level sequencer for a 2-D scaler. Accepts one frame command and,
//   for every output line, issues a horizontal line command (for the
//   horizontal sampler) and a vertical descriptor (source line, phase and
//   number of input lines to retire) for the line-buffer / vertical filter.
// Ports
//   clk      : clock
//   reset_n  : asynchronous reset, active-low
//   bus      : cory_scale_ctrl_if.slave (frame cmd in, H cmd out,
//              V descriptor out, busy/done status)
// Parameter
//   R : resolution bits; the vertical accumulator is R.8 fixed point.
// ---------------------------------------------------------------------------
module cory_scale_ctrl #(
  parameter int R = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  cory_scale_ctrl_if.slave   bus
);

  localparam int F = R + 8;  // accumulator width: integer line + 8-bit phase

  typedef enum logic [1:0] {IDLE, LINE, DONE} state_e;

  typedef struct packed {
    logic [R-1:0] pos;
    logic [7:0]   phase;
    logic [R-1:0] adv;
  } desc_t;

  // Vertical descriptor for the output line whose accumulator value is f8.
  // Positions past the last source line are clamped, and their phase is
  // zeroed so the filter does not blend against a line that does not exist.
  // The last line retires everything still outstanding so a frame always
  // consumes exactly in_h input lines.
  function automatic desc_t calc_desc(input logic [F-1:0] f8,
                                      input logic [15:0]  vr,
                                      input logic [R-1:0] in_h,
                                      input logic         last);
    desc_t        d;
    logic [F-1:0] nf8;
    logic [R-1:0] hmax;
    logic [R-1:0] pos;
    logic [R-1:0] npos;
    logic [R-1:0] cpos;
    logic [R-1:0] ncpos;
    nf8     = f8 + F'(vr);
    hmax    = in_h - R'(1);
    pos     = f8[F-1:8];
    npos    = nf8[F-1:8];
    cpos    = (pos  > hmax) ? hmax : pos;
    ncpos   = (npos > hmax) ? hmax : npos;
    d.pos   = cpos;
    d.phase = (pos > hmax) ? 8'h00 : f8[7:0];
    d.adv   = last ? (in_h - cpos) : (ncpos - cpos);
    return d;
  endfunction

  // Control state
  state_e        state_q;
  logic [F-1:0]  v_f8_q;
  logic [R-1:0]  line_q;
  logic          h_sent_q;
  logic          v_sent_q;
  // Latched frame fields
  logic [R-1:0]  in_w_q;
  logic [R-1:0]  in_h_q;
  logic [R-1:0]  out_w_q;
  logic [R-1:0]  out_h_q;
  logic [15:0]   hratio_q;
  logic [15:0]   vratio_q;
  // Registered outputs
  logic          frm_r_q;
  logic          busy_q;
  logic          done_q;
  logic          h_v_q;
  logic          v_v_q;
  desc_t         desc_q;

  // Combinational terms
  logic [R-1:0]  in_h_eff;
  logic          frm_acc;
  logic          h_acc;
  logic          v_acc;
  logic          line_done;
  logic          last_line;
  logic [F-1:0]  f8_next;
  desc_t         desc_first;
  desc_t         desc_next;

  // NOTE: every variable gets a value at the top of an always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    in_h_eff   = (bus.frm_in_h == '0) ? R'(1) : bus.frm_in_h;
    frm_acc    = bus.frm_v & frm_r_q;
    h_acc      = h_v_q & bus.h_r;
    v_acc      = v_v_q & bus.v_r;
    // A line completes when the later of the two channels is accepted.
    line_done  = (state_q == LINE) & (h_sent_q | h_acc) & (v_sent_q | v_acc);
    last_line  = (line_q == out_h_q - R'(1));
    f8_next    = v_f8_q + F'(vratio_q);
    desc_first = calc_desc('0, bus.frm_vratio, in_h_eff, bus.frm_out_h == R'(1));
    desc_next  = calc_desc(f8_next, vratio_q, in_h_q, (line_q + R'(2)) == out_h_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      v_f8_q   <= '0;
      line_q   <= '0;
      h_sent_q <= 1'b0;
      v_sent_q <= 1'b0;
      in_w_q   <= '0;
      in_h_q   <= '0;
      out_w_q  <= '0;
      out_h_q  <= '0;
      hratio_q <= '0;
      vratio_q <= '0;
      frm_r_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      h_v_q    <= 1'b0;
      v_v_q    <= 1'b0;
      desc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frm_acc) begin
            in_w_q   <= bus.frm_in_w;
            in_h_q   <= in_h_eff;
            out_w_q  <= bus.frm_out_w;
            out_h_q  <= bus.frm_out_h;
            hratio_q <= bus.frm_hratio;
            vratio_q <= bus.frm_vratio;
            v_f8_q   <= '0;
            line_q   <= '0;
            h_sent_q <= 1'b0;
            v_sent_q <= 1'b0;
            frm_r_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (bus.frm_out_h == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= LINE;
              h_v_q   <= 1'b1;
              v_v_q   <= 1'b1;
              desc_q  <= desc_first;
            end
          end
        end

        LINE: begin
          if (line_done) begin
            h_sent_q <= 1'b0;
            v_sent_q <= 1'b0;
            if (last_line) begin
              state_q <= DONE;
              h_v_q   <= 1'b0;
              v_v_q   <= 1'b0;
            end else begin
              // Next line presented immediately: no idle cycle between lines.
              v_f8_q <= f8_next;
              line_q <= line_q + R'(1);
              h_v_q  <= 1'b1;
              v_v_q  <= 1'b1;
              desc_q <= desc_next;
            end
          end else begin
            if (h_acc) begin
              h_sent_q <= 1'b1;
              h_v_q    <= 1'b0;
            end
            if (v_acc) begin
              v_sent_q <= 1'b1;
              v_v_q    <= 1'b0;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          frm_r_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.frm_r     = frm_r_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.h_v       = h_v_q;
  assign bus.h_in_cnt  = in_w_q;
  assign bus.h_out_cnt = out_w_q;
  assign bus.h_ratio   = hratio_q;
  assign bus.v_v       = v_v_q;
  assign bus.v_line    = line_q;
  assign bus.v_pos     = desc_q.pos;
  assign bus.v_phase   = desc_q.phase;
  assign bus.v_adv     = desc_q.adv;

endmodule

// File: tb/tb_cory_scale_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cory_scale_ctrl
//   Self-checking bench for cory_scale_ctrl. Frames are driven through the
//   interface, line readies are randomized, and every accepted or pending
//   command is compared with a reference model that derives each output
//   line's descriptor directly from k*vratio.
// ---------------------------------------------------------------------------
module tb_cory_scale_ctrl;

  localparam int R  = 11;
  localparam int VW = 3 * R + 8;   // {line, pos, phase, adv}
  localparam int HW = 2 * R + 16;  // {in_cnt, out_cnt, ratio}

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  cory_scale_ctrl_if #(.R(R)) bus ();

  cory_scale_ctrl #(.R(R)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: descriptor of output line k, computed from the line index.
  function automatic logic [VW-1:0] exp_v(input int k, input int ih, input int oh, input int vr);
    int ihe, f, nf, pos, npos, cp, ncp, ph, adv;
    ihe  = (ih == 0) ? 1 : ih;
    f    = (k * vr) % (1 << (R + 8));
    nf   = ((k + 1) * vr) % (1 << (R + 8));
    pos  = f / 256;
    npos = nf / 256;
    cp   = (pos  > ihe - 1) ? ihe - 1 : pos;
    ncp  = (npos > ihe - 1) ? ihe - 1 : npos;
    ph   = (pos  > ihe - 1) ? 0 : f % 256;
    adv  = (k == oh - 1) ? ihe - cp : ncp - cp;
    return {R'(k), R'(cp), 8'(ph), R'(adv)};
  endfunction

  task automatic init_inputs();
    bus.frm_v      = 1'b0;
    bus.frm_in_w   = '0;
    bus.frm_in_h   = '0;
    bus.frm_out_w  = '0;
    bus.frm_out_h  = '0;
    bus.frm_hratio = '0;
    bus.frm_vratio = '0;
    bus.h_r        = 1'b0;
    bus.v_r        = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (bus.frm_r !== 1'b1) begin
      miscompares++; $display("FAIL %s frm_r: got %b want 1", tag, bus.frm_r);
    end
    vectors++;
    if ({bus.h_v, bus.v_v, bus.busy, bus.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s h_v/v_v/busy/done: got %b want 0000", tag, {bus.h_v, bus.v_v, bus.busy, bus.done});
    end
    vectors++;
    if ({bus.h_in_cnt, bus.h_out_cnt, bus.h_ratio} !== '0) begin
      miscompares++;
      $display("FAIL %s h_fields: got %h want 0", tag, {bus.h_in_cnt, bus.h_out_cnt, bus.h_ratio});
    end
    vectors++;
    if ({bus.v_line, bus.v_pos, bus.v_phase, bus.v_adv} !== '0) begin
      miscompares++;
      $display("FAIL %s v_fields: got %h want 0", tag, {bus.v_line, bus.v_pos, bus.v_phase, bus.v_adv});
    end
  endtask

  // Runs one frame. hp/vp: ready probability in percent. For the first
  // h_hold cycles of the frame h_r is held low and v_r high.
  task automatic run_frame(input int iw, input int ih, input int ow, input int oh,
                           input int hr, input int vr, input int hp, input int vp,
                           input int h_hold);
    int line, cyc, advsum, budget, ihe;
    bit hd, vd, first;
    logic [HW-1:0] eh;
    logic [VW-1:0] ev;
    eh     = {R'(iw), R'(ow), 16'(hr)};
    ihe    = (ih == 0) ? 1 : ih;
    budget = oh * 60 + 100;

    @(negedge clk);
    vectors++;
    if (bus.frm_r !== 1'b1) begin
      miscompares++; $display("FAIL frm_r_idle: got %b want 1", bus.frm_r);
    end
    bus.frm_in_w   = R'(iw);
    bus.frm_in_h   = R'(ih);
    bus.frm_out_w  = R'(ow);
    bus.frm_out_h  = R'(oh);
    bus.frm_hratio = 16'(hr);
    bus.frm_vratio = 16'(vr);
    bus.frm_v      = 1'b1;
    @(negedge clk);
    bus.frm_v = 1'b0;

    // First cycle after accept
    vectors++;
    if ({bus.busy, bus.frm_r} !== 2'b10) begin
      miscompares++; $display("FAIL busy_after_accept: got %b want 10", {bus.busy, bus.frm_r});
    end

    line = 0; cyc = 0; advsum = 0; hd = 0; vd = 0; first = 1;
    while (line < oh && cyc < budget) begin
      if (cyc < h_hold) begin
        bus.h_r = 1'b0;
        bus.v_r = 1'b1;
      end else begin
        bus.h_r = ($urandom_range(99) < hp);
        bus.v_r = ($urandom_range(99) < vp);
      end
      if (first) begin
        vectors++;
        if ({bus.h_v, bus.v_v} !== 2'b11) begin
          miscompares++; $display("FAIL line_start line %0d: got %b want 11", line, {bus.h_v, bus.v_v});
        end
      end
      first = 0;
      vectors++;
      if ({bus.h_v, bus.v_v} !== {!hd, !vd}) begin
        miscompares++;
        $display("FAIL valid_seq line %0d: got %b want %b", line, {bus.h_v, bus.v_v}, {!hd, !vd});
      end
      if (bus.h_v === 1'b1) begin
        vectors++;
        if ({bus.h_in_cnt, bus.h_out_cnt, bus.h_ratio} !== eh) begin
          miscompares++;
          $display("FAIL h_cmd line %0d: got %h want %h", line, {bus.h_in_cnt, bus.h_out_cnt, bus.h_ratio}, eh);
        end
      end
      if (bus.v_v === 1'b1) begin
        ev = exp_v(line, ih, oh, vr);
        vectors++;
        if ({bus.v_line, bus.v_pos, bus.v_phase, bus.v_adv} !== ev) begin
          miscompares++;
          $display("FAIL v_desc line %0d: got line=%0d pos=%0d ph=%h adv=%0d want line=%0d pos=%0d ph=%h adv=%0d",
                   line, bus.v_line, bus.v_pos, bus.v_phase, bus.v_adv,
                   ev[VW-1 -: R], ev[2*R+7 -: R], ev[R+7 -: 8], ev[R-1:0]);
        end
      end
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++; $display("FAIL done_early line %0d: got %b want 0", line, bus.done);
      end
      if (bus.h_v === 1'b1 && bus.h_r) hd = 1;
      if (bus.v_v === 1'b1 && bus.v_r) begin
        vd = 1;
        advsum += int'(bus.v_adv);
      end
      if (hd && vd) begin
        line++; hd = 0; vd = 0; first = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.h_r = 1'b0;
    bus.v_r = 1'b0;

    if (line < oh) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: got %0d lines want %0d", line, oh);
    end
    if (oh > 0) begin
      vectors++;
      if (advsum !== ihe) begin
        miscompares++; $display("FAIL adv_sum: got %0d want %0d", advsum, ihe);
      end
    end
    // Cycle after the last completion (or T+1 for an empty frame): DONE state
    vectors++;
    if ({bus.h_v, bus.v_v, bus.busy, bus.done} !== 4'b0010) begin
      miscompares++;
      $display("FAIL done_state: got %b want 0010", {bus.h_v, bus.v_v, bus.busy, bus.done});
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.frm_r} !== 3'b011) begin
      miscompares++; $display("FAIL done_pulse: got %b want 011", {bus.busy, bus.done, bus.frm_r});
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL done_width: got %b want 0", bus.done);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");
  endtask

  task automatic test_unity();
    run_frame(4, 4, 4, 4, 'h100, 'h100, 100, 100, 0);
  endtask

  task automatic test_upscale();
    run_frame(4, 2, 8, 4, 'h080, 'h080, 100, 100, 0);
    run_frame(4, 2, 8, 4, 'h080, 'h080, 50, 50, 0);
  endtask

  task automatic test_downscale();
    run_frame(8, 4, 4, 2, 'h200, 'h200, 100, 100, 0);
    run_frame(4, 2, 4, 4, 'h100, 'h100, 100, 100, 0);  // positions clamp
  endtask

  task automatic test_backpressure();
    run_frame(16, 6, 12, 3, 'h155, 'h1c0, 100, 100, 5);
  endtask

  task automatic test_zero_height();
    run_frame(10, 5, 10, 0, 'h100, 'h100, 100, 100, 0);
    run_frame(10, 0, 10, 3, 'h100, 'h100, 100, 100, 0);  // in_h 0 acts as 1
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus.frm_in_w   = R'(20);
    bus.frm_in_h   = R'(8);
    bus.frm_out_w  = R'(20);
    bus.frm_out_h  = R'(6);
    bus.frm_hratio = 16'h0100;
    bus.frm_vratio = 16'h0140;
    bus.frm_v      = 1'b1;
    @(negedge clk);
    bus.frm_v = 1'b0;
    bus.h_r   = 1'b1;
    bus.v_r   = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    bus.h_r = 1'b0;
    bus.v_r = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy, bus.frm_r} !== 3'b001) begin
        miscompares++;
        $display("FAIL after_mid_reset: got %b want 001", {bus.done, bus.busy, bus.frm_r});
      end
    end
    run_frame(20, 8, 20, 6, 'h100, 'h140, 100, 100, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_frame($urandom_range(1, 2047), $urandom_range(0, 24), $urandom_range(1, 2047),
                $urandom_range(0, 24), $urandom_range(0, 16'hffff), $urandom_range(16'h10, 16'h400),
                $urandom_range(30, 100), $urandom_range(30, 100), 0);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_upscale();
    test_downscale();
    test_backpressure();
    test_zero_height();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
